e_mdu: RTL and testbench
========================

E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, multiply latency in cycles.
REQ-002 Parameter DIV_CYCLES, default 10, divide latency in cycles.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 MDOp  input  3  E-stage operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
REQ-006 Req  input  1  exception/interrupt flush for the instruction currently in E.
REQ-007 A  input  32  rs operand, forwarded.
REQ-008 B  input  32  rt operand, forwarded.
REQ-009 Busy  output  1  operation in progress.
REQ-010 HI  output  32  HI register, registered.
REQ-011 LO  output  32  LO register, registered.

Function
REQ-012 Block shall hold HI, LO, Busy, a down-counter sized for DIV_CYCLES, the latched operation type, and latched A/B.
REQ-013 Operation accepted at a posedge only when Req=0, Busy=0, and MDOp is 1-6; otherwise MDOp is ignored.
REQ-014 MULT/MULTU/DIV/DIVU accept: latch A, B, and type; counter <= MULT_CYCLES or DIV_CYCLES; Busy <= 1 at the same edge.
REQ-015 While Busy: counter decrements each posedge; at the posedge where counter==1, HI/LO are written, Busy <= 0, and counter <= 0.
REQ-016 Busy shall be high for exactly MULT_CYCLES or DIV_CYCLES cycles; new HI/LO are visible in the cycle Busy first reads 0.
REQ-017 MULT: {HI,LO} = signed(A) x signed(B), full 64 bits; MULTU: unsigned 64-bit product.
REQ-018 DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
REQ-019 DIVU: LO = unsigned quotient; HI = unsigned remainder.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF shall give LO=0x80000000, HI=0x00000000.
REQ-021 Divisor 0 (DIV or DIVU): operation still runs DIV_CYCLES with Busy high; HI and LO remain unchanged at completion.
REQ-022 MTHI: HI <= A at the accepting edge; MTLO: LO <= A; no Busy, single cycle.
REQ-023 Results shall be computed from the latched operands, so A/B changes during Busy have no effect.
REQ-024 MDOp presented while Busy=1 shall be ignored; the hazard unit stalls it, and the block adds no queueing.
REQ-025 Req=1 blocks acceptance at that edge; an already running operation continues to completion unaffected.
REQ-026 Req=1 and a start MDOp at the same edge: nothing is latched and Busy stays 0.
REQ-027 HI/LO are read combinationally from the registers; the block has no mfhi/mflo bypass of an in-flight result.

Reset
REQ-028 reset=1 shall force, asynchronously: HI=0, LO=0, Busy=0, counter=0, latched type NONE, latched A/B=0.
REQ-029 Reset during Busy shall abort the operation; HI/LO read 0 and are not written afterwards.
REQ-030 After reset deasserts, the first posedge may accept a new operation.

Verification
REQ-031 MULT A=0xFFFFFFFE(-2), B=3 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 DIV A=-7(0xFFFFFFF9), B=2 -> Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 -> Busy 10 cycles, HI/LO unchanged.
REQ-034 MTHI A=0x12345678 with Req=1 -> HI unchanged; same with Req=0 -> HI=0x12345678 next cycle, Busy never rises.
REQ-035 DIV started, MULT presented in cycle 3 of Busy and A/B changed -> MULT ignored, DIV result from the original operands.
REQ-036 DIV started, reset pulsed in cycle 4 -> Busy=0 and HI=LO=0 immediately, and they stay 0 through cycle 12.

Source files
------------

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit holding HI/LO with fixed-latency MULT/DIV,
// single-cycle MTHI/MTLO, and an in-flight operation immune to flushes.
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  MDOp,
   input  logic        Req,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSVD  = 3'd7
   } op_t;

   op_t           op_r;
   logic [31:0]   a_r;
   logic [31:0]   b_r;
   logic [CW-1:0] cnt_r;

   logic          accept_s;
   logic [63:0]   prod_s;
   logic [63:0]   produ_s;
   logic [31:0]   divisor_s;
   logic [31:0]   a_mag_s;
   logic [31:0]   b_mag_s;
   logic [31:0]   uq_s;
   logic [31:0]   ur_s;
   logic [31:0]   sq_s;
   logic [31:0]   sr_s;
   logic          res_we_s;
   logic [31:0]   res_hi_s;
   logic [31:0]   res_lo_s;

   // Acceptance qualification for a new E-stage operation
   always_comb begin
      accept_s = 1'b0;
      if (!Req && !Busy && (MDOp != OP_NONE) && (MDOp != OP_RSVD)) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
   end

   // Arithmetic datapath on the latched operands; signed divide goes through
   // magnitudes so 0x80000000 / -1 naturally wraps to 0x80000000 rem 0
   always_comb begin
      prod_s    = $signed({{32{a_r[31]}}, a_r}) * $signed({{32{b_r[31]}}, b_r});
      produ_s   = {32'd0, a_r} * {32'd0, b_r};
      divisor_s = (b_r == 32'd0) ? 32'd1 : b_r;
      a_mag_s   = a_r[31] ? (32'd0 - a_r) : a_r;
      b_mag_s   = divisor_s[31] ? (32'd0 - divisor_s) : divisor_s;
      uq_s      = a_mag_s / b_mag_s;
      ur_s      = a_mag_s % b_mag_s;
      sq_s      = (a_r[31] ^ divisor_s[31]) ? (32'd0 - uq_s) : uq_s;
      sr_s      = a_r[31] ? (32'd0 - ur_s) : ur_s;
   end

   // Result selection for the completing operation
   always_comb begin
      res_we_s = 1'b0;
      res_hi_s = HI;
      res_lo_s = LO;
      case (op_r)
         OP_MULT: begin
            res_we_s = 1'b1;
            res_hi_s = prod_s[63:32];
            res_lo_s = prod_s[31:0];
         end
         OP_MULTU: begin
            res_we_s = 1'b1;
            res_hi_s = produ_s[63:32];
            res_lo_s = produ_s[31:0];
         end
         OP_DIV: begin
            if (b_r != 32'd0) begin
               res_we_s = 1'b1;
               res_hi_s = sr_s;
               res_lo_s = sq_s;
            end else begin
               res_we_s = 1'b0;
            end
         end
         OP_DIVU: begin
            if (b_r != 32'd0) begin
               res_we_s = 1'b1;
               res_hi_s = b_r == 32'd0 ? HI : (a_r % divisor_s);
               res_lo_s = a_r / divisor_s;
            end else begin
               res_we_s = 1'b0;
            end
         end
         default: begin
            res_we_s = 1'b0;
         end
      endcase
   end

   // Operation latch, latency counter and HI/LO registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_r  <= OP_NONE;
         a_r   <= 32'd0;
         b_r   <= 32'd0;
         cnt_r <= '0;
         Busy  <= 1'b0;
         HI    <= 32'd0;
         LO    <= 32'd0;
      end else if (Busy) begin
         if (cnt_r == CNT_ONE) begin
            Busy  <= 1'b0;
            cnt_r <= '0;
            if (res_we_s) begin
               HI <= res_hi_s;
               LO <= res_lo_s;
            end
         end else begin
            cnt_r <= cnt_r - CNT_ONE;
         end
      end else if (accept_s) begin
         case (MDOp)
            OP_MULT, OP_MULTU: begin
               op_r  <= op_t'(MDOp);
               a_r   <= A;
               b_r   <= B;
               cnt_r <= MULT_LOAD;
               Busy  <= 1'b1;
            end
            OP_DIV, OP_DIVU: begin
               op_r  <= op_t'(MDOp);
               a_r   <= A;
               b_r   <= B;
               cnt_r <= DIV_LOAD;
               Busy  <= 1'b1;
            end
            OP_MTHI: HI <= A;
            OP_MTLO: LO <= A;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed vector table, hand-written corner
// sequences, and randomized operations against a plain-arithmetic model.
module tb_e_mdu;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  MDOp;
   logic        Req;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks = 0;
   int passed = 0;
   logic [31:0] hi_m = 32'd0;
   logic [31:0] lo_m = 32'd0;

   e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .MDOp(MDOp), .Req(Req),
      .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference: HI/LO after an operation, from the architectural definitions
   function automatic void model_step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint x, y, q, r;
      logic [63:0] p;
      case (op)
         3'd1: begin
            x = longint'($signed(a)); y = longint'($signed(b));
            p = 64'(x * y); hi_m = p[63:32]; lo_m = p[31:0];
         end
         3'd2: begin
            p = {32'd0, a} * {32'd0, b}; hi_m = p[63:32]; lo_m = p[31:0];
         end
         3'd3: if (b != 32'd0) begin
            x = longint'($signed(a)); y = longint'($signed(b));
            q = x / y; r = x % y; lo_m = q[31:0]; hi_m = r[31:0];
         end
         3'd4: if (b != 32'd0) begin
            lo_m = a / b; hi_m = a % b;
         end
         3'd5: hi_m = a;
         3'd6: lo_m = a;
         default: ;
      endcase
   endfunction

   function automatic int model_cycles(input logic [2:0] op);
      if (op == 3'd1 || op == 3'd2) return MC;
      if (op == 3'd3 || op == 3'd4) return DC;
      return 0;
   endfunction

   // Called #1 after a posedge with Busy low; returns observed Busy cycles
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit noise, output int cyc);
      MDOp = op; A = a; B = b; Req = 1'b0;
      @(posedge clk); #1;
      MDOp = 3'd0; cyc = 0;
      while (Busy && cyc < 200) begin
         if (noise) begin
            MDOp = 3'($urandom_range(1, 6)); A = $urandom; B = $urandom;
            Req = 1'($urandom_range(0, 1));
         end
         cyc++;
         @(posedge clk); #1;
         MDOp = 3'd0; Req = 1'b0;
      end
   endtask

   initial begin
      int cyc;
      logic [2:0]  op;
      logic [31:0] ra, rb;

      reset = 1'b1; MDOp = 3'd0; Req = 1'b0; A = 32'd0; B = 32'd0;
      #2;
      check("reset_state", {31'd0, Busy, HI}, 64'd0);
      check("reset_lo", {32'd0, LO}, 64'd0);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;

      vecs[0] = '{3'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, MC};
      vecs[1] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MC};
      vecs[2] = '{3'd1, 32'hFFFF_FFFB, 32'hFFFF_FFF9, 32'h0000_0000, 32'h0000_0023, MC};
      vecs[3] = '{3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
      vecs[4] = '{3'd4, 32'd7,         32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
      vecs[5] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DC};
      vecs[6] = '{3'd4, 32'hFFFF_FFFF, 32'h10,       32'h0000_000F, 32'h0FFF_FFFF, DC};
      vecs[7] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DC};
      vecs[8] = '{3'd6, 32'hCAFE_F00D, 32'd0,        32'h0000_0001, 32'hCAFE_F00D, 0};
      vecs[9] = '{3'd5, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'hCAFE_F00D, 0};

      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, cyc);
         check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].cyc));
         check($sformatf("vec%0d_hilo", i), {HI, LO}, {vecs[i].hi, vecs[i].lo});
      end
      hi_m = vecs[9].hi; lo_m = vecs[9].lo;

      // MTHI flushed by Req, then accepted
      MDOp = 3'd5; A = 32'hA5A5_0001; Req = 1'b1;
      @(posedge clk); #1;
      MDOp = 3'd0; Req = 1'b0;
      check("mthi_req_hi", {32'd0, HI}, {32'd0, hi_m});
      run_op(3'd5, 32'hA5A5_0001, 32'd0, 1'b0, cyc);
      check("mthi_hi", {32'd0, HI}, 64'hA5A5_0001);
      check("mthi_nobusy", 64'(cyc), 64'd0);
      hi_m = 32'hA5A5_0001;

      // Start op coinciding with Req: nothing latched
      MDOp = 3'd1; A = 32'd9; B = 32'd9; Req = 1'b1;
      @(posedge clk); #1;
      check("req_start_busy", {63'd0, Busy}, 64'd0);
      MDOp = 3'd0; Req = 1'b0;
      @(posedge clk); #1;
      check("req_start_hilo", {HI, LO}, {hi_m, lo_m});

      // DIV with MULT and new operands presented in cycle 3 of Busy
      MDOp = 3'd3; A = 32'd100; B = 32'd7;
      @(posedge clk); #1;
      MDOp = 3'd0; cyc = 0;
      while (Busy && cyc < 200) begin
         cyc++;
         if (cyc == 3) begin MDOp = 3'd1; A = 32'd1000; B = 32'd1000; end
         else if (cyc == 5) Req = 1'b1;
         @(posedge clk); #1;
         MDOp = 3'd0;
      end
      Req = 1'b0;
      check("div_ignore_cycles", 64'(cyc), 64'(DC));
      check("div_ignore_hilo", {HI, LO}, {32'd2, 32'd14});

      // Reset in cycle 4 of a DIV
      MDOp = 3'd3; A = 32'd50; B = 32'd3;
      @(posedge clk); #1;
      MDOp = 3'd0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_abort", {31'd0, Busy, HI}, 64'd0);
      check("rst_abort_lo", {32'd0, LO}, 64'd0);
      @(negedge clk); reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         check($sformatf("rst_hold%0d", i), {31'd0, Busy, HI ^ LO, LO}, 96'd0);
      end
      hi_m = 32'd0; lo_m = 32'd0;

      // First edge after reset release accepts an op
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      run_op(3'd1, 32'd3, 32'd4, 1'b0, cyc);
      check("post_rst_cycles", 64'(cyc), 64'(MC));
      check("post_rst_hilo", {HI, LO}, 64'd12);
      lo_m = 32'd12;

      // Randomized operations with bus noise during Busy
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(1, 6));
         ra = $urandom; rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            default: ;
         endcase
         run_op(op, ra, rb, 1'(i % 2), cyc);
         model_step(op, ra, rb);
         check($sformatf("rnd%0d_op%0d_cycles", i, op), 64'(cyc), 64'(model_cycles(op)));
         check($sformatf("rnd%0d_op%0d_hilo", i, op), {HI, LO}, {hi_m, lo_m});
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
